// File: rtl/cfu_bridge.sv
// cfu_bridge: registered bridge between the core CFU channels and an
// external accelerator, with ID tracking and a hang watchdog.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   s_req_*              core request in (valid/ready, id, func, data0/1)
//   m_req_*              accelerator request out, fields from registers
//   m_resp_*             accelerator response in (id, status, data)
//   s_resp_*             core response out, FWFT head of response FIFO
//   outstanding          number of requests in flight
//   err_unexpected       sticky, response for a non-pending ID seen
//   err_timeout          sticky, watchdog fired and pending IDs flushed
//   perf_*               counters, only with CFU_BRIDGE_PERF_EN defined
module cfu_bridge #(
    parameter int DATA_W          = 32,
    parameter int REQ_ID_W        = 3,
    parameter int FUNC_W          = 10,
    parameter int STATUS_W        = 3,
    parameter int MAX_OUTSTANDING = 4,
    parameter int RESP_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES  = 1024,
    parameter logic [STATUS_W-1:0] ERR_STATUS = STATUS_W'(2)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_req_valid,
    output logic                  s_req_ready,
    input  logic [REQ_ID_W-1:0]   s_req_id,
    input  logic [FUNC_W-1:0]     s_req_func,
    input  logic [DATA_W-1:0]     s_req_data0,
    input  logic [DATA_W-1:0]     s_req_data1,
    output logic                  m_req_valid,
    input  logic                  m_req_ready,
    output logic [REQ_ID_W-1:0]   m_req_id,
    output logic [FUNC_W-1:0]     m_req_func,
    output logic [DATA_W-1:0]     m_req_data0,
    output logic [DATA_W-1:0]     m_req_data1,
    input  logic                  m_resp_valid,
    output logic                  m_resp_ready,
    input  logic [REQ_ID_W-1:0]   m_resp_id,
    input  logic [STATUS_W-1:0]   m_resp_status,
    input  logic [DATA_W-1:0]     m_resp_data,
    output logic                  s_resp_valid,
    input  logic                  s_resp_ready,
    output logic [REQ_ID_W-1:0]   s_resp_id,
    output logic [STATUS_W-1:0]   s_resp_status,
    output logic [DATA_W-1:0]     s_resp_data,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
    output logic                  err_unexpected,
    output logic                  err_timeout
`ifdef CFU_BRIDGE_PERF_EN
    ,
    output logic [31:0]           perf_req_count,
    output logic [31:0]           perf_resp_count,
    output logic [31:0]           perf_stall_cycles
`endif
);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING+1);
    localparam int NID   = 2**REQ_ID_W;
    localparam int AW    = RESP_DEPTH > 1 ? $clog2(RESP_DEPTH) : 1;
    localparam int WD_W  = TIMEOUT_CYCLES > 0 ?
                           $clog2(TIMEOUT_CYCLES+1) : 1;

    typedef struct packed {
        logic [REQ_ID_W-1:0] id;
        logic [FUNC_W-1:0]   func;
        logic [DATA_W-1:0]   d0;
        logic [DATA_W-1:0]   d1;
    } req_t;

    typedef struct packed {
        logic [REQ_ID_W-1:0] id;
        logic [STATUS_W-1:0] st;
        logic [DATA_W-1:0]   data;
    } rsp_t;

    typedef enum logic {RUN, FLUSH} state_t;

    state_t           state;
    req_t             in_req, o_req, k_req;
    logic             o_valid, k_valid;
    logic [NID-1:0]   pending, pend_nxt;
    logic [WD_W-1:0]  wd, wd_inc;
    rsp_t             mem [RESP_DEPTH];
    rsp_t             push_ent;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic [REQ_ID_W-1:0] low_id, ret_id;
    logic req_acc, resp_acc, run_acc, hit, full;
    logic flush_push, push, pop, retire, timeout_hit;

    function automatic logic [AW-1:0] ptr_nxt(input logic [AW-1:0] p);
        return (p == AW'(RESP_DEPTH-1)) ? '0 : p + AW'(1);
    endfunction

    assign in_req = '{s_req_id, s_req_func, s_req_data0, s_req_data1};

    assign s_req_ready = !(o_valid && k_valid)
                       && (outstanding < OUT_W'(MAX_OUTSTANDING))
                       && !pending[s_req_id]
                       && (state == RUN);
    assign req_acc = s_req_valid && s_req_ready;

    assign m_req_valid = o_valid;
    assign m_req_id    = o_req.id;
    assign m_req_func  = o_req.func;
    assign m_req_data0 = o_req.d0;
    assign m_req_data1 = o_req.d1;

    // Skid: o_* is the visible output stage, k_* catches one extra beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid <= 1'b0;
            k_valid <= 1'b0;
        end else if (o_valid && !m_req_ready) begin
            if (req_acc) begin
                k_valid <= 1'b1;
                k_req   <= in_req;
            end
        end else if (k_valid) begin
            o_req   <= k_req;
            o_valid <= 1'b1;
            k_valid <= req_acc;
            if (req_acc) k_req <= in_req;
        end else begin
            o_valid <= req_acc;
            if (req_acc) o_req <= in_req;
        end
    end

    assign full         = (count == (AW+1)'(RESP_DEPTH));
    assign m_resp_ready = (state == FLUSH) || !full;
    assign resp_acc     = m_resp_valid && m_resp_ready;
    // Late beats during FLUSH are swallowed, not forwarded.
    assign run_acc      = resp_acc && (state == RUN);
    assign hit          = pending[m_resp_id];
    assign flush_push   = (state == FLUSH) && !full && (|pending);
    assign push         = run_acc || flush_push;
    assign retire       = (run_acc && hit) || flush_push;
    assign ret_id       = flush_push ? low_id : m_resp_id;

    always_comb begin
        low_id = '0;
        for (int i = NID-1; i >= 0; i--)
            if (pending[i]) low_id = REQ_ID_W'(i);
    end

    always_comb begin
        push_ent = '{m_resp_id,
                     hit ? m_resp_status : ERR_STATUS,
                     m_resp_data};
        if (flush_push) push_ent = '{low_id, ERR_STATUS, '0};
    end

    always_comb begin
        pend_nxt = pending;
        if (req_acc) pend_nxt[s_req_id] = 1'b1;
        if (retire)  pend_nxt[ret_id]   = 1'b0;
    end

    assign pop           = s_resp_valid && s_resp_ready;
    assign s_resp_valid  = (count != '0);
    assign s_resp_id     = mem[rd_ptr].id;
    assign s_resp_status = mem[rd_ptr].st;
    assign s_resp_data   = mem[rd_ptr].data;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_ent;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_nxt(wr_ptr);
            if (pop)  rd_ptr <= ptr_nxt(rd_ptr);
            unique case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign wd_inc = wd + WD_W'(1);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state == RUN)
                       && !resp_acc && (outstanding != '0)
                       && (wd_inc == WD_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= RUN;
            pending        <= '0;
            outstanding    <= '0;
            wd             <= '0;
            err_unexpected <= 1'b0;
            err_timeout    <= 1'b0;
        end else begin
            pending <= pend_nxt;
            unique case ({req_acc, retire})
                2'b10:   outstanding <= outstanding + OUT_W'(1);
                2'b01:   outstanding <= outstanding - OUT_W'(1);
                default: outstanding <= outstanding;
            endcase
            if (TIMEOUT_CYCLES == 0 || resp_acc ||
                outstanding == '0 || state == FLUSH)
                wd <= '0;
            else
                wd <= wd_inc;
            if (run_acc && !hit) err_unexpected <= 1'b1;
            unique case (state)
                RUN: begin
                    if (timeout_hit) begin
                        state       <= FLUSH;
                        err_timeout <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (pending == '0) state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef CFU_BRIDGE_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_req_count    <= '0;
            perf_resp_count   <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (req_acc)
                perf_req_count <= perf_req_count + 32'd1;
            if (pop)
                perf_resp_count <= perf_resp_count + 32'd1;
            if (s_req_valid && !s_req_ready)
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cfu_bridge.sv
// tb_cfu_bridge: scoreboard bench for cfu_bridge with an echoing
// accelerator model and a core-side response sink.
module tb_cfu_bridge;
    localparam int DW = 32;
    localparam int IW = 3;
    localparam int FW = 10;
    localparam int SW = 3;
    localparam logic [2:0] ERR = 3'd2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic s_req_valid = 1'b0;
    logic s_req_ready;
    logic [IW-1:0] s_req_id = '0;
    logic [FW-1:0] s_req_func = '0;
    logic [DW-1:0] s_req_data0 = '0;
    logic [DW-1:0] s_req_data1 = '0;
    logic m_req_valid;
    logic m_req_ready = 1'b1;
    logic [IW-1:0] m_req_id;
    logic [FW-1:0] m_req_func;
    logic [DW-1:0] m_req_data0, m_req_data1;
    logic m_resp_valid = 1'b0;
    logic m_resp_ready;
    logic [IW-1:0] m_resp_id = '0;
    logic [SW-1:0] m_resp_status = '0;
    logic [DW-1:0] m_resp_data = '0;
    logic s_resp_valid;
    logic s_resp_ready = 1'b1;
    logic [IW-1:0] s_resp_id;
    logic [SW-1:0] s_resp_status;
    logic [DW-1:0] s_resp_data;
    logic [2:0] outstanding;
    logic err_unexpected, err_timeout;
`ifdef CFU_BRIDGE_PERF_EN
    logic [31:0] perf_req_count, perf_resp_count, perf_stall_cycles;
`endif

    cfu_bridge #(
        .DATA_W(DW), .REQ_ID_W(IW), .FUNC_W(FW), .STATUS_W(SW),
        .MAX_OUTSTANDING(4), .RESP_DEPTH(4),
        .TIMEOUT_CYCLES(16), .ERR_STATUS(ERR)
    ) dut (
        .clk(clk), .rst(rst),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
        .s_req_id(s_req_id), .s_req_func(s_req_func),
        .s_req_data0(s_req_data0), .s_req_data1(s_req_data1),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
        .m_req_id(m_req_id), .m_req_func(m_req_func),
        .m_req_data0(m_req_data0), .m_req_data1(m_req_data1),
        .m_resp_valid(m_resp_valid), .m_resp_ready(m_resp_ready),
        .m_resp_id(m_resp_id), .m_resp_status(m_resp_status),
        .m_resp_data(m_resp_data),
        .s_resp_valid(s_resp_valid), .s_resp_ready(s_resp_ready),
        .s_resp_id(s_resp_id), .s_resp_status(s_resp_status),
        .s_resp_data(s_resp_data),
        .outstanding(outstanding),
        .err_unexpected(err_unexpected), .err_timeout(err_timeout)
`ifdef CFU_BRIDGE_PERF_EN
        ,
        .perf_req_count(perf_req_count),
        .perf_resp_count(perf_resp_count),
        .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  id;
        logic [2:0]  st;
        logic [31:0] data;
    } rsp_t;

    typedef struct {
        logic [2:0]  id;
        logic [2:0]  st;
        logic [31:0] data;
        int          due;
    } acc_t;

    rsp_t sb[$];
    acc_t aq[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   n_sent = 0;
    bit   acc_en = 1'b1;
    bit   f_sreq, f_mreq, f_mresp;
    logic [2:0]  l_id;
    logic [31:0] l_sum;
    int   peak_out;
    bit   full_stall, over_accept;
    int   sreq_edge, mresp_edge;
    int   mreq_edges[$];
    int   mreq_ids[$];

    // One clock: sample just before the edge, update models after it.
    task automatic tick();
        rsp_t e;
        #1;
        f_sreq  = s_req_valid && s_req_ready;
        f_mreq  = m_req_valid && m_req_ready;
        f_mresp = m_resp_valid && m_resp_ready;
        l_id    = m_req_id;
        l_sum   = m_req_data0 + m_req_data1;
        if (f_sreq) sreq_edge = cyc + 1;
        if (f_mresp) mresp_edge = cyc + 1;
        if (f_mreq) begin
            mreq_edges.push_back(cyc + 1);
            mreq_ids.push_back(int'(m_req_id));
        end
        if (int'(outstanding) > peak_out) peak_out = int'(outstanding);
        if (s_req_valid && outstanding == 3'd4) begin
            if (s_req_ready) over_accept = 1'b1;
            else full_stall = 1'b1;
        end
        if (s_resp_valid && s_resp_ready && !rst) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL resp_extra got id=%0d st=%0d data=%h expected none",
                         s_resp_id, s_resp_status, s_resp_data);
            end else begin
                e = sb.pop_front();
                if (s_resp_id !== e.id || s_resp_status !== e.st ||
                    s_resp_data !== e.data) begin
                    n_fail++;
                    $display("FAIL resp got id=%0d st=%0d data=%h expected id=%0d st=%0d data=%h",
                             s_resp_id, s_resp_status, s_resp_data,
                             e.id, e.st, e.data);
                end
            end
        end
        @(negedge clk);
        cyc++;
        if (rst) begin
            aq.delete();
        end else begin
            if (f_mresp && aq.size() > 0) aq.delete(0);
            if (f_mreq && acc_en)
                aq.push_back('{l_id, 3'd0, l_sum, cyc + 2});
        end
        if (aq.size() > 0 && aq[0].due <= cyc) begin
            m_resp_valid  = 1'b1;
            m_resp_id     = aq[0].id;
            m_resp_status = aq[0].st;
            m_resp_data   = aq[0].data;
        end else begin
            m_resp_valid = 1'b0;
        end
        #1;
    endtask

    task automatic send(input logic [2:0] id,
                        input logic [31:0] d0,
                        input logic [31:0] d1);
        int w = 0;
        s_req_valid = 1'b1;
        s_req_id    = id;
        s_req_func  = {7'd0, id} + 10'h40;
        s_req_data0 = d0;
        s_req_data1 = d1;
        tick();
        while (!f_sreq && w < 100) begin
            tick();
            w++;
        end
        if (!f_sreq) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_accept id=%0d got no accept expected accept", id);
        end else begin
            n_sent++;
        end
        s_req_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while ((sb.size() != 0 || aq.size() != 0) && w < 200) begin
            tick();
            w++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain got %0d left expected 0", sb.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        n_cmp++;
        if (m_req_valid !== 1'b0 || s_resp_valid !== 1'b0 ||
            outstanding !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_valid got mv=%b sv=%b out=%0d expected 0 0 0",
                     m_req_valid, s_resp_valid, outstanding);
        end
        n_cmp++;
        if (err_unexpected !== 1'b0 || err_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_err got %b%b expected 00",
                     err_unexpected, err_timeout);
        end
        n_cmp++;
        if (s_req_ready !== 1'b1 || m_resp_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready got %b%b expected 11",
                     s_req_ready, m_resp_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        peak_out    = 0;
        full_stall  = 1'b0;
        over_accept = 1'b0;
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = $urandom;
            sb.push_back('{3'(i), 3'd0, a + b});
            send(3'(i), a, b);
        end
        drain();
        n_cmp++;
        if (peak_out != 4) begin
            n_fail++;
            $display("FAIL b2b_peak got %0d expected 4", peak_out);
        end
        n_cmp++;
        if (full_stall !== 1'b1 || over_accept !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_ready_at_4 got stall=%b over=%b expected 1 0",
                     full_stall, over_accept);
        end
        n_cmp++;
        if (err_unexpected !== 1'b0 || outstanding !== 3'd0) begin
            n_fail++;
            $display("FAIL b2b_end got err=%b out=%0d expected 0 0",
                     err_unexpected, outstanding);
        end
    endtask

    task automatic test_id_hazard();
        sb.push_back('{3'd2, 3'd0, 32'h30});
        send(3'd2, 32'h10, 32'h20);
        sb.push_back('{3'd2, 3'd0, 32'h300});
        send(3'd2, 32'h100, 32'h200);
        n_cmp++;
        if (sreq_edge != mresp_edge + 1) begin
            n_fail++;
            $display("FAIL hazard_edge got %0d expected %0d",
                     sreq_edge, mresp_edge + 1);
        end
        drain();
    endtask

    task automatic test_backpressure();
        int w = 0;
        bit stable = 1'b1;
        bit order_ok = 1'b1;
        m_req_ready = 1'b0;
        mreq_edges.delete();
        mreq_ids.delete();
        sb.push_back('{3'd5, 3'd0, 32'h55});
        send(3'd5, 32'h50, 32'h05);
        sb.push_back('{3'd6, 3'd0, 32'h66});
        send(3'd6, 32'h60, 32'h06);
        sb.push_back('{3'd7, 3'd0, 32'h77});
        s_req_valid = 1'b1;
        s_req_id    = 3'd7;
        s_req_func  = 10'h47;
        s_req_data0 = 32'h70;
        s_req_data1 = 32'h07;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (f_sreq || m_req_valid !== 1'b1 || m_req_id !== 3'd5 ||
                m_req_func !== 10'h45 || m_req_data0 !== 32'h50 ||
                m_req_data1 !== 32'h05)
                stable = 1'b0;
        end
        n_cmp++;
        if (!stable) begin
            n_fail++;
            $display("FAIL bp_hold got unstable/accepted expected held id=5 ready=0");
        end
        m_req_ready = 1'b1;
        tick();
        while (!f_sreq && w < 20) begin
            tick();
            w++;
        end
        if (f_sreq) n_sent++;
        s_req_valid = 1'b0;
        repeat (3) tick();
        if (mreq_ids.size() != 3) order_ok = 1'b0;
        else if (mreq_ids[0] != 5 || mreq_ids[1] != 6 ||
                 mreq_ids[2] != 7 ||
                 mreq_edges[1] != mreq_edges[0] + 1 ||
                 mreq_edges[2] != mreq_edges[1] + 1)
            order_ok = 1'b0;
        n_cmp++;
        if (!order_ok) begin
            n_fail++;
            $display("FAIL bp_issue got %0d issues expected 3 consecutive ids 5,6,7",
                     mreq_ids.size());
        end
        drain();
    endtask

    task automatic test_unexpected();
        n_cmp++;
        if (err_unexpected !== 1'b0 || outstanding !== 3'd0) begin
            n_fail++;
            $display("FAIL unexp_pre got err=%b out=%0d expected 0 0",
                     err_unexpected, outstanding);
        end
        aq.push_back('{3'd5, 3'd1, 32'hDEAD_BEEF, 0});
        sb.push_back('{3'd5, ERR, 32'hDEAD_BEEF});
        drain();
        tick();
        n_cmp++;
        if (err_unexpected !== 1'b1 || outstanding !== 3'd0) begin
            n_fail++;
            $display("FAIL unexp_flag got err=%b out=%0d expected 1 0",
                     err_unexpected, outstanding);
        end
    endtask

    task automatic test_timeout();
        int c0;
        int w = 0;
        n_cmp++;
        if (err_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL to_pre got %b expected 0", err_timeout);
        end
        acc_en = 1'b0;
        sb.push_back('{3'd1, ERR, 32'd0});
        sb.push_back('{3'd3, ERR, 32'd0});
        send(3'd1, 32'h11, 32'h1);
        c0 = sreq_edge;
        send(3'd3, 32'h33, 32'h3);
        s_req_id = 3'd0;
        while (err_timeout !== 1'b1 && w < 60) begin
            tick();
            w++;
        end
        n_cmp++;
        if (err_timeout !== 1'b1 || cyc - c0 != 16) begin
            n_fail++;
            $display("FAIL to_fire got flag=%b after %0d expected 1 after 16",
                     err_timeout, cyc - c0);
        end
        n_cmp++;
        if (s_req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL to_flush_ready got %b expected 0", s_req_ready);
        end
        drain();
        repeat (2) tick();
        n_cmp++;
        if (outstanding !== 3'd0 || s_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL to_end got out=%0d ready=%b expected 0 1",
                     outstanding, s_req_ready);
        end
        acc_en = 1'b1;
    endtask

    task automatic test_reset_midflight();
        int w = 0;
        s_resp_ready = 1'b0;
        send(3'd0, 32'h1, 32'h2);
        send(3'd1, 32'h3, 32'h4);
        while (outstanding !== 3'd0 && w < 50) begin
            tick();
            w++;
        end
        acc_en = 1'b0;
        send(3'd2, 32'h5, 32'h6);
        send(3'd3, 32'h7, 32'h8);
        m_req_ready = 1'b0;
        send(3'd4, 32'h9, 32'hA);
        tick();
        n_cmp++;
        if (outstanding !== 3'd3 || s_resp_valid !== 1'b1 ||
            m_req_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rmf_pre got out=%0d sv=%b mv=%b expected 3 1 1",
                     outstanding, s_resp_valid, m_req_valid);
        end
`ifdef CFU_BRIDGE_PERF_EN
        n_cmp++;
        if (perf_req_count !== 32'(n_sent)) begin
            n_fail++;
            $display("FAIL perf_req got %0d expected %0d",
                     perf_req_count, n_sent);
        end
`endif
        rst = 1'b1;
        tick();
        n_cmp++;
        if (m_req_valid !== 1'b0 || s_resp_valid !== 1'b0 ||
            outstanding !== 3'd0) begin
            n_fail++;
            $display("FAIL rmf_valid got mv=%b sv=%b out=%0d expected 0 0 0",
                     m_req_valid, s_resp_valid, outstanding);
        end
        n_cmp++;
        if (err_unexpected !== 1'b0 || err_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL rmf_err got %b%b expected 00",
                     err_unexpected, err_timeout);
        end
`ifdef CFU_BRIDGE_PERF_EN
        n_cmp++;
        if (perf_req_count !== 32'd0 || perf_resp_count !== 32'd0 ||
            perf_stall_cycles !== 32'd0) begin
            n_fail++;
            $display("FAIL rmf_perf got %0d %0d %0d expected 0 0 0",
                     perf_req_count, perf_resp_count, perf_stall_cycles);
        end
`endif
        rst = 1'b0;
        n_sent = 0;
        m_req_ready = 1'b1;
        s_resp_ready = 1'b1;
        acc_en = 1'b1;
        repeat (2) tick();
        n_cmp++;
        if (s_req_ready !== 1'b1 || s_resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rmf_after got ready=%b sv=%b expected 1 0",
                     s_req_ready, s_resp_valid);
        end
    endtask

    initial begin
        @(negedge clk);
        #1;
        test_reset();
        test_back_to_back();
        test_id_hazard();
        test_backpressure();
        test_unexpected();
        test_timeout();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
